// File: rtl/gnn_out_collector_if.sv
// rtl/gnn_out_collector_if.sv - result stream bundle (word, slot index, valid/ready) for gnn_out_collector
interface gnn_out_collector_if #(
  parameter int OW = 21
);
  logic signed [OW-1:0] m_data;
  logic [2:0]           m_idx;
  logic                 m_valid;
  logic                 m_ready;

  modport master (output m_data, output m_idx, output m_valid, input m_ready);
  modport slave  (input m_data, input m_idx, input m_valid, output m_ready);
endinterface

// File: rtl/gnn_out_collector.sv
// rtl/gnn_out_collector.sv - captures the 2*NODES layer-2 results of one inference and streams them in slot order
// Optional per-node argmax outputs (class_node/class_valid) enabled by defining GNN_OUT_ARGMAX_EN.
module gnn_out_collector #(
  parameter int OW    = 21,
  parameter int NODES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_ready,
  input  logic signed [OW-1:0] out0_node0,
  input  logic signed [OW-1:0] out1_node0,
  input  logic signed [OW-1:0] out0_node1,
  input  logic signed [OW-1:0] out1_node1,
  input  logic signed [OW-1:0] out0_node2,
  input  logic signed [OW-1:0] out1_node2,
  input  logic signed [OW-1:0] out0_node3,
  input  logic signed [OW-1:0] out1_node3,
  input  logic                 out10_ready_node0,
  input  logic                 out11_ready_node0,
  input  logic                 out10_ready_node1,
  input  logic                 out11_ready_node1,
  input  logic                 out10_ready_node2,
  input  logic                 out11_ready_node2,
  input  logic                 out10_ready_node3,
  input  logic                 out11_ready_node3,
  gnn_out_collector_if.master  m,
  output logic                 busy,
  output logic                 done,
  output logic                 overrun
`ifdef GNN_OUT_ARGMAX_EN
  ,
  output logic [NODES-1:0]     class_node,
  output logic                 class_valid
`endif
);

  localparam int SLOTS = 2 * NODES;
  localparam logic [2:0] LAST_IDX = 3'(SLOTS - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, STREAM} state_t;

  state_t               state_q, state_d;
  logic [SLOTS-1:0]     mask_q, mask_d;
  logic signed [OW-1:0] slot_q [SLOTS];
  logic signed [OW-1:0] slot_d [SLOTS];
  logic [2:0]           idx_q, idx_d;
  logic                 valid_q, valid_d;
  logic signed [OW-1:0] data_q, data_d;
  logic                 done_q, done_d;
  logic                 overrun_q, overrun_d;

  logic signed [OW-1:0] res [SLOTS];
  logic [SLOTS-1:0]     flag;

  // Slot k = node*2 + out, so flag/result vectors share one index space.
  always_comb begin
    res[0] = out0_node0;
    res[1] = out1_node0;
    res[2] = out0_node1;
    res[3] = out1_node1;
    res[4] = out0_node2;
    res[5] = out1_node2;
    res[6] = out0_node3;
    res[7] = out1_node3;
    flag   = {out11_ready_node3, out10_ready_node3, out11_ready_node2, out10_ready_node2,
              out11_ready_node1, out10_ready_node1, out11_ready_node0, out10_ready_node0};
  end

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    slot_d    = slot_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    data_d    = data_q;
    done_d    = 1'b0;
    overrun_d = overrun_q;
    case (state_q)
      IDLE: begin
        if (in_ready) begin
          state_d = COLLECT;
          mask_d  = '0;
        end
      end
      COLLECT: begin
        // A relaunch wins over both completion and any capture in the same cycle.
        if (in_ready) begin
          mask_d = '0;
        end else if (&mask_q) begin
          state_d = STREAM;
          idx_d   = '0;
          valid_d = 1'b1;
          data_d  = slot_q[0];
        end else begin
          for (int k = 0; k < SLOTS; k++) begin
            if (flag[k] && !mask_q[k]) begin
              slot_d[k] = res[k];
              mask_d[k] = 1'b1;
            end
          end
        end
      end
      STREAM: begin
        if (in_ready) overrun_d = 1'b1;
        if (valid_q && m.m_ready) begin
          if (idx_q == LAST_IDX) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d  = idx_q + 3'd1;
            data_d = slot_q[idx_q + 3'd1];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mask_q    <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      for (int k = 0; k < SLOTS; k++) slot_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
      slot_q    <= slot_d;
    end
  end

  assign m.m_data  = data_q;
  assign m.m_idx   = idx_q;
  assign m.m_valid = valid_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign overrun   = overrun_q;

`ifdef GNN_OUT_ARGMAX_EN
  logic [NODES-1:0] class_q, class_d;

  // Decision is frozen from the captured slots at the moment streaming starts.
  always_comb begin
    class_d = class_q;
    if (state_q == COLLECT && state_d == STREAM) begin
      for (int n = 0; n < NODES; n++) class_d[n] = (slot_q[2*n+1] > slot_q[2*n]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) class_q <= '0;
    else     class_q <= class_d;
  end

  assign class_node  = class_q;
  assign class_valid = valid_q;
`endif

endmodule
